seg7_serial_receiver: RTL and testbench

//  Display-board end of the 4-wire serial 7-segment link. Samples the serial

---
 rtl/seg7_serial_receiver.sv | 113 +++++++++++
 tb/tb_seg7_serial_receiver.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_serial_receiver.sv
// Display-board end of the 4-wire serial 7-segment link: deserializes 64-bit
// frames, commits them to a pattern register and scans 8 active-low digits.
module seg7_serial_receiver #(
  parameter int SCAN_DIV   = 50000,
  parameter int FRAME_BITS = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            ser_in,
  output logic [FRAME_BITS-1:0] pattern,
  output logic                  frame_ok,
  output logic                  frame_err,
  output logic [7:0]            segment,
  output logic [7:0]            anode
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [6:0]    CNT_FULL  = 7'(FRAME_BITS);
  localparam logic [6:0]    CNT_OVF   = 7'(FRAME_BITS + 1);

  logic [3:0]            sync1;
  logic [3:0]            sync2;
  logic                  sclk_d;
  logic                  load_d;
  logic                  sclk_rise;
  logic                  load_rise;
  logic                  sdata;
  logic                  en;
  logic [FRAME_BITS-1:0] shreg;
  logic [FRAME_BITS-1:0] shreg_nxt;
  logic [6:0]            bit_cnt;
  logic [6:0]            cnt_nxt;
  logic [CW-1:0]         scan_cnt;
  logic [2:0]            scan_idx;

  // Two-stage synchronizer on every pin, plus a third stage on the two edge-sensitive ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      sclk_d <= 1'b0;
      load_d <= 1'b0;
    end else begin
      sync1  <= ser_in;
      sync2  <= sync1;
      sclk_d <= sync2[3];
      load_d <= sync2[1];
    end
  end

  assign sclk_rise = sync2[3] & ~sclk_d;
  assign load_rise = sync2[1] & ~load_d;
  assign sdata     = sync2[2];
  assign en        = sync2[0];

  // The shift/count result of this cycle feeds the commit check, so a bit
  // arriving together with s_load still counts toward the frame.
  always_comb begin
    shreg_nxt = shreg;
    cnt_nxt   = bit_cnt;
    if (!en) begin
      cnt_nxt = '0;
    end else if (sclk_rise) begin
      shreg_nxt = {shreg[FRAME_BITS-2:0], sdata};
      if (bit_cnt != CNT_OVF) cnt_nxt = bit_cnt + 7'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      pattern   <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      shreg     <= shreg_nxt;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      if (load_rise) begin
        bit_cnt <= '0;
        if (cnt_nxt == CNT_FULL) begin
          pattern  <= shreg_nxt;
          frame_ok <= 1'b1;
        end else begin
          frame_err <= 1'b1;
        end
      end else begin
        bit_cnt <= cnt_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      scan_idx <= '0;
      anode    <= 8'hFE;
      segment  <= 8'hFF;
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        scan_idx <= scan_idx + 3'd1;
      end else begin
        scan_cnt <= scan_cnt + CW'(1);
      end
      anode   <= ~(8'b1 << scan_idx);
      segment <= ~pattern[{scan_idx, 3'b000} +: 8];
    end
  end

endmodule

// File: tb/tb_seg7_serial_receiver.sv
// Randomized bench for seg7_serial_receiver: a frame-level model predicts each
// commit; a monitor checks pulses, pattern and the scan outputs every cycle.
module tb_seg7_serial_receiver;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_clk = 1'b0, s_data = 1'b0, s_load = 1'b0, s_en = 1'b0;
  wire  [3:0]  ser_in = {s_clk, s_data, s_load, s_en};
  logic [63:0] pattern;
  logic        frame_ok, frame_err;
  logic [7:0]  segment, anode;

  seg7_serial_receiver #(.SCAN_DIV(D), .FRAME_BITS(64)) dut (
    .clk(clk), .rst(rst), .ser_in(ser_in), .pattern(pattern),
    .frame_ok(frame_ok), .frame_err(frame_err), .segment(segment), .anode(anode)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_q = 1'b0;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  typedef struct {
    int          due;
    bit          ok;
    logic [63:0] pat;
  } exp_t;

  exp_t        exq[$];
  bit          sent[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] cur_pat = '0;
  int          last_rst = 0;
  bit          seen_rst = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: reset values, scan walk, commit pulses and pattern, every cycle.
  exp_t        e;
  int          mk, midx;
  logic [7:0]  exp_an, exp_seg;
  always @(negedge clk) begin
    if (rst_q) begin
      seen_rst = 1'b1;
      last_rst = cyc;
      cur_pat  = '0;
      chk("rst_pattern", pattern, 64'h0);
      chk("rst_anode", anode, 64'hFE);
      chk("rst_segment", segment, 64'hFF);
      chk("rst_pulses", {frame_ok, frame_err}, 64'h0);
    end else if (seen_rst) begin
      mk      = cyc - last_rst;
      midx    = ((mk - 1) / D) % 8;
      exp_an  = ~(8'b1 << midx);
      exp_seg = ~cur_pat[8*midx +: 8];
      chk("anode", anode, exp_an);
      chk("segment", segment, exp_seg);
      if (exq.size() > 0 && exq[0].due == cyc) begin
        e = exq.pop_front();
        chk("frame_ok", frame_ok, e.ok);
        chk("frame_err", frame_err, !e.ok);
        if (e.ok) cur_pat = e.pat;
      end else begin
        chk("no_pulse", {frame_ok, frame_err}, 64'h0);
      end
      chk("pattern", pattern, cur_pat);
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_load();
    exp_t        x;
    logic [63:0] p = '0;
    foreach (sent[i]) p = {p[62:0], sent[i]};
    x.due = cyc + 3;
    x.ok  = (sent.size() == 64);
    x.pat = p;
    exq.push_back(x);
    sent.delete();
  endtask

  task automatic send_bit(bit b, bit with_load);
    s_data = b;
    tick($urandom_range(3, 5));
    s_clk = 1'b1;
    if (s_en) sent.push_back(b);
    if (with_load) begin
      s_load = 1'b1;
      push_load();
    end
    tick($urandom_range(3, 5));
    s_clk  = 1'b0;
    s_load = 1'b0;
  endtask

  task automatic send_frame(logic [63:0] v, int n);
    for (int i = 0; i < n; i++)
      send_bit((i < 64) ? v[63-i] : 1'($urandom), 1'b0);
  endtask

  task automatic do_load();
    tick(2);
    s_load = 1'b1;
    push_load();
    tick(4);
    s_load = 1'b0;
    tick(3);
  endtask

  task automatic en_on();
    s_en = 1'b1;
    tick(4);
  endtask

  task automatic en_off();
    s_en = 1'b0;
    sent.delete();
    tick(4);
  endtask

  task automatic do_reset();
    s_clk = 1'b0; s_load = 1'b0; s_en = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    sent.delete();
    tick(2);
  endtask

  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    miscompares++;
    summary();
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] v;
    int          n;
    do_reset();
    tick(5);

    en_on();
    send_frame(64'h0123456789ABCDEF, 64);
    do_load();

    send_frame({$urandom, $urandom}, 63);
    do_load();
    send_frame({$urandom, $urandom}, 65);
    do_load();

    send_frame(64'h80FF_FFFF_FFFF_FF01, 64);
    do_load();
    tick(80);

    send_frame({$urandom, $urandom}, 30);
    en_off();
    en_on();
    send_frame({$urandom, $urandom}, 64);
    do_load();

    v = {$urandom, $urandom};
    for (int i = 0; i < 63; i++) send_bit(v[63-i], 1'b0);
    send_bit(v[0], 1'b1);
    tick(6);

    send_frame({$urandom, $urandom}, 20);
    do_reset();
    en_on();
    do_load();

    en_off();
    do_load();
    en_on();

    for (int r = 0; r < 6; r++) begin
      case ($urandom_range(0, 4))
        0:       n = 63;
        1:       n = 65;
        2:       n = $urandom_range(0, 10);
        default: n = 64;
      endcase
      send_frame({$urandom, $urandom}, n);
      do_load();
      tick($urandom_range(0, 12));
    end

    for (int w = 0; w < 50 && exq.size() > 0; w++) tick(1);
    chk("queue_drained", exq.size(), 64'h0);
    summary();
    $finish;
  end

endmodule
